// File: rtl/shift_cmd_queue.sv
// Command queue in front of the 8-bit barrel shifter: valid/ready in, FWFT head out.
// Holds up to DEPTH {data, dir, shamt} commands in arrival order.
module shift_cmd_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_dir,
    input  logic [2:0]               in_shamt,
    output logic                     sh_valid,
    input  logic                     sh_ready,
    output logic [7:0]               sh_in,
    output logic                     sh_dir,
    output logic [2:0]               sh_shamt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       dir;
        logic [2:0] shamt;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    cmd_t          head;

    assign in_ready = (count_q != CW'(DEPTH)) & ~flush;
    assign sh_valid = (count_q != '0);
    assign push     = in_valid & in_ready;
    assign pop      = sh_valid & sh_ready;
    assign count    = count_q;

    // Head is forced to zero while empty so stale storage never leaks out.
    assign head     = mem_q[rd_ptr_q];
    assign sh_in    = sh_valid ? head.data  : 8'h00;
    assign sh_dir   = sh_valid ? head.dir   : 1'b0;
    assign sh_shamt = sh_valid ? head.shamt : 3'h0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; push is already blocked during flush via in_ready.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_t'({in_data, in_dir, in_shamt});
    end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: directed scenarios plus random traffic against a queue model.
module tb_shift_cmd_queue;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic [2:0] in_shamt;
    logic       sh_valid;
    logic       sh_ready;
    logic [7:0] sh_in;
    logic       sh_dir;
    logic [2:0] sh_shamt;
    logic [2:0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] model[$];

    shift_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .in_shamt (in_shamt),
        .sh_valid (sh_valid),
        .sh_ready (sh_ready),
        .sh_in    (sh_in),
        .sh_dir   (sh_dir),
        .sh_shamt (sh_shamt),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle (entered just after a falling edge), compare outputs to the model, then advance the model.
    task automatic step(input logic f, input logic v, input logic [7:0] d, input logic dr,
                        input logic [2:0] sa, input logic rdy);
        logic [11:0] hd;
        logic        acc;
        logic        rem;
        flush = f; in_valid = v; in_data = d; in_dir = dr; in_shamt = sa; sh_ready = rdy;
        #1;
        hd = (model.size() != 0) ? model[0] : 12'h000;
        check("count",    32'(count),    32'(model.size()));
        check("in_ready", 32'(in_ready), 32'((model.size() != DEPTH) && !f));
        check("sh_valid", 32'(sh_valid), 32'(model.size() != 0));
        check("sh_in",    32'(sh_in),    32'(hd[11:4]));
        check("sh_dir",   32'(sh_dir),   32'(hd[3]));
        check("sh_shamt", 32'(sh_shamt), 32'(hd[2:0]));
        acc = v && (model.size() != DEPTH) && !f;
        rem = rdy && (model.size() != 0) && !f;
        @(posedge clk);
        if (f) model.delete();
        else begin
            if (rem) void'(model.pop_front());
            if (acc) model.push_back({d, dr, sa});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 3'h0, 1'b0);
    endtask

    logic [7:0] drain_exp [4];

    initial begin
        drain_exp[0] = 8'hA5; drain_exp[1] = 8'h3C; drain_exp[2] = 8'hFF; drain_exp[3] = 8'h01;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
        in_shamt = '0; sh_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle();

        // Fill to full; fifth offer must be refused.
        step(1'b0, 1'b1, 8'hA5, 1'b1, 3'd3, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b0, 3'd1, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd7, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b1, 3'd5, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_head",  32'({sh_in, sh_dir, sh_shamt}), 32'({8'hA5, 1'b1, 3'd3}));

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check("drain_head", 32'(sh_in), 32'(drain_exp[i]));
            step(1'b0, 1'b0, 8'h00, 1'b0, 3'h0, 1'b1);
        end
        check("empty_sh_in", 32'(sh_in), 32'd0);
        idle();

        // Hold occupancy at 2 while pushing and popping each cycle.
        step(1'b0, 1'b1, 8'h0E, 1'b0, 3'd2, 1'b0);
        step(1'b0, 1'b1, 8'h0F, 1'b1, 3'd4, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 8'(8'h10 + i), 1'(i), 3'(i), 1'b1);
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_head",  32'(sh_in), 32'h18);

        // Refill to full, then offer and pop together.
        step(1'b0, 1'b1, 8'h40, 1'b0, 3'd6, 1'b0);
        step(1'b0, 1'b1, 8'h41, 1'b1, 3'd1, 1'b0);
        step(1'b0, 1'b1, 8'h42, 1'b1, 3'd2, 1'b1);
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_ready", 32'(in_ready), 32'd1);
        idle();

        // Flush beats push and pop in the same cycle.
        step(1'b1, 1'b1, 8'hEE, 1'b1, 3'd7, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(sh_valid), 32'd0);
        idle();

        // Asynchronous reset with three entries queued.
        step(1'b0, 1'b1, 8'h51, 1'b0, 3'd1, 1'b0);
        step(1'b0, 1'b1, 8'h52, 1'b1, 3'd2, 1'b0);
        step(1'b0, 1'b1, 8'h53, 1'b0, 3'd3, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_count", 32'(count),    32'd0);
        check("rst_valid", 32'(sh_valid), 32'd0);
        check("rst_sh_in", 32'(sh_in),    32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        model.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h99, 1'b1, 3'd4, 1'b0);
        check("post_rst_head", 32'(sh_in), 32'h99);

        // Random traffic with occasional flush.
        for (int i = 0; i < 2000; i++)
            step(1'(($urandom % 32) == 0), 1'($urandom % 4 != 0), 8'($urandom),
                 1'($urandom), 3'($urandom), 1'($urandom % 3 != 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
